// File: rtl/axi_burst_master.sv
// axi_burst_master
//   Issues one INCR burst per command on an AXI4 master port. A write moves
//   cmd_len+1 beats from the wr_* stream onto W. A read moves cmd_len+1 beats
//   from R onto the rd_* stream. Each command ends with a one-cycle done pulse
//   carrying the burst status on done_resp.
//
// Optional feature: define AXI_MASTER_TIMEOUT_EN to add an 8-bit watchdog.
//   The watchdog aborts a burst after TIMEOUT_CYCLES cycles with no handshake
//   and reports done_resp = 2'b11. When the macro is undefined, the FSM waits
//   indefinitely.
//
// Handshake rule (every channel): a transfer happens on the rising edge where
//   valid && ready are both high. A valid, once raised, keeps its payload
//   stable until that edge. cmd_valid is honoured only while cmd_ready is high.
//
// Ports
//   m00_axi_aclk / m00_axi_areset : clock, async active-high reset
//   cmd_*       : command in (write flag, 6-bit address, len = beats-1)
//   wr_*        : write data stream in (valid/ready)
//   rd_*        : read data stream out (valid/ready)
//   done, done_resp : completion pulse and status
//   m00_axi_aw*/w*/b*/ar*/r* : AXI4 master channels
//   dbg_state   : current FSM state, for debug
module axi_burst_master #(
  parameter logic [1:0] AXI_ID         = 2'b11,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        m00_axi_aclk,
  input  logic        m00_axi_areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic [1:0]  done_resp,
  output logic [5:0]  m00_axi_awaddr,
  output logic [7:0]  m00_axi_awlen,
  output logic [2:0]  m00_axi_awsize,
  output logic [1:0]  m00_axi_awburst,
  output logic [1:0]  m00_axi_awid,
  output logic        m00_axi_awvalid,
  input  logic        m00_axi_awready,
  output logic [31:0] m00_axi_wdata,
  output logic [3:0]  m00_axi_wstrb,
  output logic        m00_axi_wlast,
  output logic        m00_axi_wvalid,
  input  logic        m00_axi_wready,
  input  logic [1:0]  m00_axi_bresp,
  input  logic [1:0]  m00_axi_bid,
  input  logic        m00_axi_bvalid,
  output logic        m00_axi_bready,
  output logic [5:0]  m00_axi_araddr,
  output logic [7:0]  m00_axi_arlen,
  output logic [2:0]  m00_axi_arsize,
  output logic [1:0]  m00_axi_arburst,
  output logic        m00_axi_arvalid,
  input  logic        m00_axi_arready,
  input  logic [31:0] m00_axi_rdata,
  input  logic [1:0]  m00_axi_rresp,
  input  logic        m00_axi_rlast,
  input  logic        m00_axi_rvalid,
  output logic        m00_axi_rready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AW = 3'd1, S_W = 3'd2, S_B = 3'd3,
    S_AR = 3'd4, S_R = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic [1:0]  err_q, err_d;
  // Low during reset and until the first edge after release, which delays
  // the first cmd_ready by one clock.
  logic        rdy_q;
  logic        last_beat;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_q, wd_d;
  logic       wd_active, wd_hs;
`endif

  // The command fields are registered at acceptance, so AW/AR stay stable.
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_awlen   = len_q;
  assign m00_axi_arlen   = len_q;
  assign m00_axi_awsize  = 3'b010;
  assign m00_axi_arsize  = 3'b010;
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_arburst = 2'b01;
  assign m00_axi_awid    = AXI_ID;
  assign m00_axi_wstrb   = 4'hF;
  assign m00_axi_wdata   = wr_data;
  assign rd_data         = m00_axi_rdata;
  assign done_resp       = err_q;
  assign dbg_state       = state_q;
  assign last_beat       = (beat_q == len_q);

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    err_d           = err_q;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    rd_valid        = 1'b0;
    done            = 1'b0;
    m00_axi_awvalid = 1'b0;
    m00_axi_wvalid  = 1'b0;
    m00_axi_wlast   = 1'b0;
    m00_axi_bready  = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = rdy_q;
        if (cmd_valid && rdy_q) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          beat_d  = '0;
          err_d   = 2'b00;
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        m00_axi_awvalid = 1'b1;
        if (m00_axi_awready) state_d = S_W;
      end
      S_W: begin
        m00_axi_wvalid = wr_valid;
        wr_ready       = m00_axi_wready;
        m00_axi_wlast  = last_beat;
        if (wr_valid && m00_axi_wready) begin
          if (last_beat) state_d = S_B;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      S_B: begin
        m00_axi_bready = 1'b1;
        if (m00_axi_bvalid) begin
          // A response for another ID is reported as a slave error.
          err_d   = (m00_axi_bid != AXI_ID) ? 2'b10 : m00_axi_bresp;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        m00_axi_arvalid = 1'b1;
        if (m00_axi_arready) state_d = S_R;
      end
      S_R: begin
        m00_axi_rready = rd_ready;
        rd_valid       = m00_axi_rvalid;
        if (m00_axi_rvalid && rd_ready) begin
          // The first error wins. Within one beat, a bad rresp is reported
          // ahead of a misplaced or missing rlast.
          if (err_q == 2'b00) begin
            if (m00_axi_rresp != 2'b00)          err_d = m00_axi_rresp;
            else if (m00_axi_rlast != last_beat) err_d = 2'b10;
          end
          if (m00_axi_rlast || last_beat) state_d = S_DONE;
          else                            beat_d  = beat_q + 8'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    wd_active = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B) ||
                (state_q == S_AR) || (state_q == S_R);
    wd_hs     = ((state_q == S_AW) && m00_axi_awready) ||
                ((state_q == S_W)  && wr_valid && m00_axi_wready) ||
                ((state_q == S_B)  && m00_axi_bvalid) ||
                ((state_q == S_AR) && m00_axi_arready) ||
                ((state_q == S_R)  && m00_axi_rvalid && rd_ready);
    wd_d      = (!wd_active || wd_hs) ? 8'd0 : wd_q + 8'd1;
    // Abort: DONE drives every AXI valid/ready low from the next cycle on.
    if (wd_active && !wd_hs && (wd_q == WdLast)) begin
      state_d = S_DONE;
      err_d   = 2'b11;
    end
`endif
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) wd_q <= '0;
    else                wd_q <= wd_d;
  end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Testbench for axi_burst_master. An AXI slave and the stream endpoints are
// driven on the falling edge, and outputs are sampled 1 ns later. Expected
// beats and status come from a transaction-level model of the burst rules:
// data is held in exp_q and each final status is computed up front.
module tb_axi_burst_master;
  localparam logic [1:0] ID = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, done;
  logic [1:0]  done_resp;
  logic [5:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, dbg_state;
  logic [1:0]  awburst, arburst, awid, bresp, bid, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wdat[256];
  logic [31:0] s_data[256];
  logic [1:0]  s_resp[256];
  bit          s_last[256];

  axi_burst_master #(.AXI_ID(ID), .TIMEOUT_CYCLES(16)) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
    .m00_axi_awburst(awburst), .m00_axi_awid(awid), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bid(bid), .m00_axi_bvalid(bvalid),
    .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
    .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic drive_idle();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic send_cmd(input bit wr, input logic [5:0] addr, input logic [7:0] len);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready got %b exp 1", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic run_write(input logic [5:0] addr, input logic [7:0] len, input int gap_beat,
                           input int aw_delay, input logic [1:0] bresp_v,
                           input logic [1:0] bid_v, input bit rnd);
    logic [1:0]  exp_resp;
    logic [31:0] e;
    int src = 0, seen = 0, aw_wait = 0, b_cnt = 0, b_delay, cyc = 0;
    bit aw_ok = 0, gap_used = 0, w_done = 0, b_done = 0, got_done = 0, in_w;
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(wdat[i]);
    exp_resp = (bid_v != ID) ? 2'b10 : bresp_v;
    b_delay = rnd ? int'($urandom_range(0, 2)) : 0;
    send_cmd(1'b1, addr, len);
    while (!got_done && cyc < 2000) begin
      @(negedge clk); cyc++;
      awready = (aw_wait >= aw_delay);
      if (src == gap_beat && !gap_used) begin
        wr_valid = 0; gap_used = 1;
      end else begin
        wr_valid = (src <= int'(len)) && (!rnd || $urandom_range(0, 3) != 0);
      end
      wr_data = (src <= int'(len)) ? wdat[src] : 32'h0;
      wready  = !rnd || ($urandom_range(0, 2) != 0);
      bvalid  = w_done && !b_done && (b_cnt >= b_delay);
      bresp   = bresp_v; bid = bid_v;
      if (w_done) b_cnt++;
      #1;
      in_w = aw_ok && !w_done;
      checks++;
      if (awvalid !== !aw_ok) begin
        errors++; $display("FAIL awvalid got %b exp %b", awvalid, !aw_ok);
      end
      if (awvalid) begin
        checks++; aw_wait++;
        if (awaddr !== addr || awlen !== len || awsize !== 3'b010 ||
            awburst !== 2'b01 || awid !== ID) begin
          errors++;
          $display("FAIL aw_fields got %h/%h/%b/%b/%b exp %h/%h/010/01/%b",
                   awaddr, awlen, awsize, awburst, awid, addr, len, ID);
        end
      end
      checks++;
      if (wr_ready !== (in_w ? wready : 1'b0)) begin
        errors++; $display("FAIL wr_ready got %b exp %b", wr_ready, in_w ? wready : 1'b0);
      end
      checks++;
      if (bready !== (w_done && !b_done)) begin
        errors++; $display("FAIL bready got %b exp %b", bready, w_done && !b_done);
      end
      if (wvalid) begin
        checks++;
        if (!in_w) begin errors++; $display("FAIL w_outside_burst got wvalid 1 exp 0"); end
      end
      if (wvalid && wready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL w_extra_beat got %h exp none", wdata);
        end else begin
          e = exp_q.pop_front();
          if (wdata !== e || wlast !== (seen == int'(len)) || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL w_beat%0d got %h last %b strb %h exp %h last %b strb f",
                     seen, wdata, wlast, wstrb, e, seen == int'(len));
          end
        end
        seen++;
        if (wlast) w_done = 1;
      end
      if (wr_valid && wr_ready) src++;
      if (bvalid && bready) b_done = 1;
      if (done) begin
        got_done = 1; checks++;
        if (done_resp !== exp_resp || !b_done || seen != int'(len) + 1) begin
          errors++;
          $display("FAIL wr_done got resp %b beats %0d exp resp %b beats %0d",
                   done_resp, seen, exp_resp, int'(len) + 1);
        end
      end
      if (awvalid && awready) aw_ok = 1;
    end
    if (!got_done) begin
      checks++; errors++; $display("FAIL wr_done_timeout got none exp done");
    end
    @(negedge clk); drive_idle(); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_done_pulse got done %b ready %b exp 0 1", done, cmd_ready);
    end
  endtask

  task automatic run_read(input logic [5:0] addr, input logic [7:0] len,
                          input int stall, input bit rnd);
    logic [1:0]  exp_resp = 2'b00;
    logic [31:0] e;
    int n_acc = 0, k = 0, cyc = 0, stall_left = stall;
    bit ar_ok = 0, r_done = 0, got_done = 0, in_r;
    // Reference: the burst ends at the first rlast or at beat len. Status is
    // the first bad rresp or framing error seen, in beat order.
    for (int i = 0; i < 256; i++) begin
      if (exp_resp == 2'b00) begin
        if (s_resp[i] != 2'b00)                 exp_resp = s_resp[i];
        else if (s_last[i] != (i == int'(len))) exp_resp = 2'b10;
      end
      exp_q.push_back(s_data[i]);
      if (s_last[i] || i == int'(len)) begin n_acc = i + 1; break; end
    end
    send_cmd(1'b0, addr, len);
    while (!got_done && cyc < 2000) begin
      @(negedge clk); cyc++;
      arready = !rnd || ($urandom_range(0, 1) != 0);
      rvalid  = ar_ok && (k < n_acc) && (!rnd || $urandom_range(0, 3) != 0);
      rdata   = s_data[k < 256 ? k : 0];
      rresp   = s_resp[k < 256 ? k : 0];
      rlast   = s_last[k < 256 ? k : 0];
      if (ar_ok && stall_left > 0) begin rd_ready = 0; stall_left--; end
      else rd_ready = !rnd || ($urandom_range(0, 2) != 0);
      #1;
      in_r = ar_ok && !r_done;
      checks++;
      if (arvalid !== !ar_ok) begin
        errors++; $display("FAIL arvalid got %b exp %b", arvalid, !ar_ok);
      end
      if (arvalid) begin
        checks++;
        if (araddr !== addr || arlen !== len || arsize !== 3'b010 || arburst !== 2'b01) begin
          errors++;
          $display("FAIL ar_fields got %h/%h/%b/%b exp %h/%h/010/01",
                   araddr, arlen, arsize, arburst, addr, len);
        end
      end
      checks++;
      if (rready !== (in_r ? rd_ready : 1'b0) || rd_valid !== (in_r ? rvalid : 1'b0)) begin
        errors++;
        $display("FAIL r_pass got rready %b rd_valid %b exp %b %b",
                 rready, rd_valid, in_r ? rd_ready : 1'b0, in_r ? rvalid : 1'b0);
      end
      if (rvalid && rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL r_extra_beat got %h exp none", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++; $display("FAIL r_beat%0d got %h exp %h", k, rd_data, e);
          end
        end
        k++;
        if (k == n_acc) r_done = 1;
      end
      if (done) begin
        got_done = 1; checks++;
        if (done_resp !== exp_resp || k != n_acc) begin
          errors++;
          $display("FAIL rd_done got resp %b beats %0d exp resp %b beats %0d",
                   done_resp, k, exp_resp, n_acc);
        end
      end
      if (arvalid && arready) ar_ok = 1;
    end
    if (!got_done) begin
      checks++; errors++; $display("FAIL rd_done_timeout got none exp done");
    end
    @(negedge clk); drive_idle(); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rd_done_pulse got done %b ready %b exp 0 1", done, cmd_ready);
    end
  endtask

  task automatic clear_slave();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      s_data[i] = $urandom; s_resp[i] = 2'b00; s_last[i] = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; drive_idle();
    wr_valid = 1; wready = 1; rvalid = 1; rd_ready = 1; cmd_valid = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 0 || awvalid !== 0 || wvalid !== 0 || wlast !== 0 || bready !== 0 ||
        arvalid !== 0 || rready !== 0 || rd_valid !== 0 || wr_ready !== 0 || done !== 0) begin
      errors++; $display("FAIL reset_ctrl got nonzero valid/ready exp all 0");
    end
    checks++;
    if (done_resp !== 0 || awaddr !== 0 || araddr !== 0 || awlen !== 0 || arlen !== 0) begin
      errors++; $display("FAIL reset_regs got %b %h %h %h %h exp 0", done_resp, awaddr, araddr, awlen, arlen);
    end
    drive_idle(); rst = 0; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", cmd_ready); end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b exp 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    wdat[0] = 32'hFFFFFFFF;
    run_write(6'h04, 8'd0, -1, 1, 2'b00, ID, 1'b0);
  endtask

  task automatic test_burst_write();
    wdat[0] = 32'hABABABAB; wdat[1] = 32'hCDCDCDCD; wdat[2] = 32'hEFEFEFEF; wdat[3] = 32'h12121212;
    run_write(6'h08, 8'd3, 1, 3, 2'b00, ID, 1'b0);
    // Wrong bid is reported as a slave error.
    run_write(6'h0C, 8'd1, -1, 0, 2'b00, 2'b01, 1'b0);
  endtask

  task automatic test_read();
    clear_slave();
    s_data[0] = 32'hAAAAAAAA; s_data[1] = 32'h55555555; s_last[1] = 1;
    run_read(6'h04, 8'd1, 2, 1'b0);
  endtask

  task automatic test_read_errors();
    clear_slave(); s_last[1] = 1;          // early rlast
    run_read(6'h10, 8'd3, 0, 1'b0);
    clear_slave();                          // rlast missing on last beat
    run_read(6'h14, 8'd1, 0, 1'b0);
    clear_slave(); s_last[2] = 1; s_resp[1] = 2'b11; s_resp[2] = 2'b10;
    run_read(6'h18, 8'd2, 0, 1'b0);         // first bad rresp wins
  endtask

  task automatic test_reset_mid_w();
    int n = 0, cyc = 0;
    for (int i = 0; i < 4; i++) wdat[i] = $urandom;
    send_cmd(1'b1, 6'h20, 8'd3);
    while (n < 2 && cyc < 50) begin
      @(negedge clk); cyc++;
      awready = 1; wr_valid = 1; wready = 1; wr_data = wdat[n];
      #1 if (wvalid && wready) n++;
    end
    @(posedge clk);
    @(negedge clk); rst = 1; #1;
    checks++;
    if (wvalid !== 0 || awvalid !== 0 || bready !== 0 || done !== 0 || cmd_ready !== 0) begin
      errors++;
      $display("FAIL reset_mid_w got w %b aw %b b %b done %b rdy %b exp 0",
               wvalid, awvalid, bready, done, cmd_ready);
    end
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL ready_after_mid_reset got %b done %b exp 1 0", cmd_ready, done);
    end
    wdat[0] = 32'h13572468;
    run_write(6'h24, 8'd0, -1, 0, 2'b00, ID, 1'b0);
  endtask

  task automatic test_timeout();
    int stalls = 0, cyc = 0;
    bit got = 0;
    send_cmd(1'b1, 6'h30, 8'd0);
    while (!got && cyc < 100) begin
      @(negedge clk); cyc++;
      awready = 1; wr_valid = 1; wready = 1; wr_data = 32'h0BADF00D; bvalid = 0;
      #1;
      if (bready) stalls++;
      if (done) begin
        got = 1;
`ifdef AXI_MASTER_TIMEOUT_EN
        checks++;
        if (stalls != 16 || done_resp !== 2'b11 || bready !== 0 || wvalid !== 0 || awvalid !== 0) begin
          errors++;
          $display("FAIL timeout_done got stalls %0d resp %b exp 16 11", stalls, done_resp);
        end
`endif
      end
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    if (!got) begin checks++; errors++; $display("FAIL timeout_missing got none exp done"); end
    @(negedge clk); drive_idle();
`else
    checks++;
    if (got || bready !== 1'b1) begin
      errors++; $display("FAIL no_timeout got done %b bready %b exp 0 1", got, bready);
    end
    @(negedge clk); drive_idle(); rst = 1;
    @(negedge clk); rst = 0;
    @(posedge clk);
`endif
  endtask

  task automatic test_len_boundaries();
    for (int i = 0; i < 256; i++) wdat[i] = $urandom;
    run_write(6'h3F, 8'd255, -1, 0, 2'b00, ID, 1'b0);
    clear_slave(); s_last[0] = 1;
    run_read(6'h00, 8'd0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] len;
    int p;
    for (int t = 0; t < 12; t++) begin
      len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0) begin
        for (int i = 0; i <= int'(len); i++) wdat[i] = $urandom;
        run_write(6'($urandom), len, -1, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                  ($urandom_range(0, 5) == 0) ? 2'b00 : ID, 1'b1);
      end else begin
        clear_slave();
        p = int'($urandom_range(0, int'(len) + 1));
        if (p <= int'(len)) s_last[p] = 1;
        if (p == int'(len) && $urandom_range(0, 2) == 0)
          s_resp[$urandom_range(0, int'(len))] = 2'($urandom_range(1, 3));
        run_read(6'($urandom), len, int'($urandom_range(0, 2)), 1'b1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_read();
    test_read_errors();
    test_reset_mid_w();
    test_timeout();
    test_len_boundaries();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter: AXI_ID, default 2'b11, value driven on m00_axi_awid.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, watchdog limit in cycles (used only with AXI_MASTER_TIMEOUT_EN).
REQ-003 One clock and one reset; reset is asynchronous and active-high.
REQ-004 Port m00_axi_aclk, in, 1: the single clock; all logic on its rising edge.
REQ-005 Port m00_axi_areset, in, 1: asynchronous active-high reset.
REQ-006 Command ports:
- cmd_valid in 1, cmd_ready out 1.
- cmd_write in 1: 1=write, 0=read.
- cmd_addr in 6.
- cmd_len in 8: beats-1.
REQ-007 Write-stream ports: wr_data in 32, wr_valid in 1, wr_ready out 1.
REQ-008 Read-stream ports: rd_data out 32, rd_valid out 1, rd_ready in 1.
REQ-009 Status ports: done out 1, a one-cycle pulse; done_resp out 2.
REQ-010 AW ports: m00_axi_awaddr out 6, awlen out 8, awsize out 3, awburst out 2, awid out 2, awvalid out 1, awready in 1.
REQ-011 W ports: m00_axi_wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1.
REQ-012 B ports: m00_axi_bresp in 2, bid in 2, bvalid in 1, bready out 1.
REQ-013 AR ports: m00_axi_araddr out 6, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-014 R ports: m00_axi_rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.

Function
REQ-015 FSM states: IDLE, AW, W, B, AR, R, DONE.
REQ-016 IDLE: cmd_ready=1. On cmd_valid, register addr/len/dir, clear beat counter and error flag, then go to AW (write) or AR (read).
REQ-017 Fixed burst fields: awsize=arsize=3'b010, awburst=arburst=2'b01 (INCR), wstrb=4'hF, awid=AXI_ID.
REQ-018 AW: awvalid=1 with registered addr/len, held stable until awready; on handshake go to W. W never starts before the AW handshake.
REQ-019 W: wvalid=wr_valid, wr_ready=wready, wdata=wr_data. Beat counter increments on wvalid&&wready. wlast=1 when counter==len. Handshake with wlast -> B.
REQ-020 B: bready=1. On bvalid, capture bresp; if bid!=AXI_ID, capture 2'b10. Go to DONE.
REQ-021 AR: arvalid=1 until arready, then go to R.
REQ-022 R: rready=rd_ready, rd_valid=rvalid, rd_data=rdata. Count beats on rvalid&&rready.
- First non-OKAY rresp is latched.
- rlast on beat!=len, or no rlast on beat==len, latches 2'b10.
- R exits on the handshake with rlast, or with beat==len, whichever comes first.
REQ-023 DONE: done=1 for exactly one cycle, done_resp = latched status (2'b00 if clean), then IDLE. Command-to-next-cmd_ready minimum is len+5 cycles for zero-wait writes.
REQ-024 cmd_valid outside IDLE is ignored (cmd_ready=0). wr_data is not consumed outside W.
REQ-025 len=0 is a single beat with wlast on the first beat. len=255 is 256 beats; the beat counter is 8-bit and does not wrap before exit.

Reset
REQ-026 Reset asserted forces state IDLE immediately, including mid-burst.
REQ-027 On reset, all valid/ready/last outputs, done, and the counter are 0. done_resp=0, awaddr=araddr=0, awlen=arlen=0.
REQ-028 The first cmd_ready=1 occurs on the first clock edge after reset is released.

Configuration
REQ-029 Macro AXI_MASTER_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles in AW/W/B/AR/R without a handshake, and clears on any handshake. When it reaches TIMEOUT_CYCLES, all AXI valids/readies drop, state goes to DONE with done_resp=2'b11.
- Undefined: no watchdog; the FSM waits indefinitely.

Verification
REQ-030 Single write: addr 6'h04, len 0, data 32'hFFFFFFFF, awready after 1 cycle, bresp 0 -> one W beat with wlast=1, done=1 with done_resp=2'b00.
REQ-031 4-beat write: addr 6'h08, len 3, data AB../CD../EF../12.. with wr_valid gap on beat 2 -> wlast only on beat 4, awlen=3, no W beat before awready.
REQ-032 Read: addr 6'h04, len 1, slave returns 32'hAAAAAAAA then 32'h55555555 with rlast on beat 2; rd_ready stalls 2 cycles -> rd_data in order, done_resp=0.
REQ-033 Read with early rlast: len 3, rlast on beat 2 -> done_resp=2'b10 after beat 2, back to IDLE.
REQ-034 Reset mid-W (after 2 of 4 beats) -> wvalid/awvalid/bready=0 immediately, no done, cmd_ready=1 after release.
REQ-035 With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, bvalid held 0 -> done at 16 stalled cycles, done_resp=2'b11; without the macro, no done.
